alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 112 +++++++++++
 tb/tb_alu_issue_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue stage in front of an external combinational ALU: register file,
// operand forwarding from EX/WB, and EX/WB pipeline registers with backpressure.
module alu_issue_stage #(
  parameter  int W    = 32,
  parameter  int NREG = 8,
  localparam int RI   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RI-1:0] in_rd,
  input  logic [RI-1:0] in_rs1,
  input  logic [RI-1:0] in_rs2,
  input  logic [W-1:0]  in_imm,
  input  logic          in_use_imm,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_op,
  input  logic [W-1:0]  alu_y,
  input  logic          alu_zero,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [RI-1:0] wb_rd,
  output logic [W-1:0]  wb_data,
  output logic          wb_zero
);

  logic          stall;
  logic          ex_valid;
  logic [3:0]    ex_op;
  logic [W-1:0]  ex_a;
  logic [W-1:0]  ex_b;
  logic [RI-1:0] ex_rd;
  logic [W-1:0]  rf [NREG];
  logic [W-1:0]  opnd_a;
  logic [W-1:0]  opnd_b;

  assign stall    = wb_valid & ~wb_ready;
  assign in_ready = ~stall;

  assign alu_a  = ex_a;
  assign alu_b  = ex_b;
  assign alu_op = ex_op;

  // Youngest producer wins: EX (result still on the ALU) before WB before the file.
  function automatic logic [W-1:0] resolve(
    input logic [RI-1:0] idx,
    input logic [W-1:0]  rf_val,
    input logic          ex_v,
    input logic [RI-1:0] ex_d,
    input logic [W-1:0]  ex_y,
    input logic          wb_v,
    input logic [RI-1:0] wb_d,
    input logic [W-1:0]  wb_y
  );
    if (idx == '0)                resolve = '0;
    else if (ex_v && ex_d == idx) resolve = ex_y;
    else if (wb_v && wb_d == idx) resolve = wb_y;
    else                          resolve = rf_val;
  endfunction

  // NOTE: every output of a combinational block is assigned on every path
  // (here via the function's full if/else chain), so no latch is inferred.
  always_comb begin
    opnd_a = resolve(in_rs1, rf[in_rs1], ex_valid, ex_rd, alu_y,
                     wb_valid, wb_rd, wb_data);
    if (in_use_imm)
      opnd_b = in_imm;
    else
      opnd_b = resolve(in_rs2, rf[in_rs2], ex_valid, ex_rd, alu_y,
                       wb_valid, wb_rd, wb_data);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_rd    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      wb_zero  <= 1'b0;
    end else if (!stall) begin
      ex_valid <= in_valid;
      ex_op    <= in_op;
      ex_a     <= opnd_a;
      ex_b     <= opnd_b;
      ex_rd    <= in_rd;
      wb_valid <= ex_valid;
      wb_rd    <= ex_rd;
      wb_data  <= alu_y;
      wb_zero  <= alu_zero;
    end
  end

  // NOTE: the register file is cleared on reset because its contents are
  // architecturally visible afterwards; a reset-less array would read X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_valid && wb_ready && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; a small combinational ALU sits on the
// alu_* ports and retired results are logged at the falling edge.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_zero;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] q_data[$];
  logic [2:0]  q_rd[$];
  logic        q_zero[$];
  int          q_cyc[$];

  alu_issue_stage #(.W(32), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_zero(wb_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'd0:    alu_y = alu_a + alu_b;
      4'd1:    alu_y = alu_a - alu_b;
      4'd2:    alu_y = alu_a & alu_b;
      4'd3:    alu_y = alu_a | alu_b;
      4'd4:    alu_y = alu_a ^ alu_b;
      4'd5:    alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'd6:    alu_y = alu_a << alu_b[4:0];
      4'd7:    alu_y = alu_a >> alu_b[4:0];
      default: alu_y = 32'd0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // A handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      q_data.push_back(wb_data);
      q_rd.push_back(wb_rd);
      q_zero.push_back(wb_zero);
      q_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [31:0] imm, input logic use_imm);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_imm     = imm;
    in_use_imm = use_imm;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] imm, input logic use_imm);
    set_in(op, rd, rs1, rs2, imm, use_imm);
    step();
  endtask

  task automatic set_idle();
    in_valid   = 1'b0;
    in_op      = 4'd0;
    in_rd      = 3'd0;
    in_rs1     = 3'd0;
    in_rs2     = 3'd0;
    in_imm     = 32'd0;
    in_use_imm = 1'b0;
  endtask

  task automatic clear_log();
    q_data.delete();
    q_rd.delete();
    q_zero.delete();
    q_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb_ready = 1'b1;
    set_in(4'd3, 3'd5, 3'd1, 3'd2, 32'hDEAD_BEEF, 1'b1);
    #7;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++;
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
    vectors++;
    if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_alu_ports got a=%h b=%h op=%h exp 0/0/0", alu_a, alu_b, alu_op);
    end
    step();
    step();
    vectors++;
    if (wb_valid !== 1'b0 || alu_a !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_held got wb_valid=%b alu_a=%h exp 0/0", wb_valid, alu_a);
    end
    rst_n = 1'b1;
  endtask

  // First edge after reset release accepts ADD r1, r0, #5.
  task automatic test_imm();
    clear_log();
    issue(4'd0, 3'd1, 3'd0, 3'd0, 32'd5, 1'b1);
    set_idle();
    vectors++;
    if (wb_valid !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd5 || alu_op !== 4'd0) begin
      miscompares++;
      $display("FAIL imm_ex_stage got wb_valid=%b a=%h b=%h op=%h exp 0/0/5/0", wb_valid, alu_a, alu_b, alu_op);
    end
    step();
    vectors++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd1 || wb_data !== 32'd5 || wb_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL imm_wb got valid=%b rd=%0d data=%h zero=%b exp 1/1/5/0", wb_valid, wb_rd, wb_data, wb_zero);
    end
    step();
    vectors++;
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL imm_drain got wb_valid=%b exp=0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d[3];
    exp_d = '{32'd7, 32'd14, 32'd7};
    clear_log();
    issue(4'd0, 3'd1, 3'd0, 3'd0, 32'd7, 1'b1);
    issue(4'd0, 3'd2, 3'd1, 3'd1, 32'd0, 1'b0);
    issue(4'd1, 3'd3, 3'd2, 3'd1, 32'd0, 1'b0);
    set_idle();
    step(); step(); step();
    vectors++;
    if (q_data.size() != 3) begin
      miscompares++;
      $display("FAIL b2b_count got=%0d exp=3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (q_data[i] !== exp_d[i] || q_rd[i] !== 3'(i + 1)) begin
          miscompares++;
          $display("FAIL b2b_result%0d got rd=%0d data=%h exp rd=%0d data=%h", i, q_rd[i], q_data[i], i + 1, exp_d[i]);
        end
      end
      vectors++;
      if (q_cyc[1] != q_cyc[0] + 1 || q_cyc[2] != q_cyc[1] + 1) begin
        miscompares++;
        $display("FAIL b2b_bubbles got cycles %0d,%0d,%0d exp consecutive", q_cyc[0], q_cyc[1], q_cyc[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    wb_ready = 1'b1;
    issue(4'd0, 3'd1, 3'd0, 3'd0, 32'd1, 1'b1);
    issue(4'd0, 3'd2, 3'd0, 3'd0, 32'd2, 1'b1);
    wb_ready = 1'b0;
    set_in(4'd0, 3'd3, 3'd0, 3'd0, 32'd3, 1'b1);
    #1;
    vectors++;
    if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd1) begin
      miscompares++;
      $display("FAIL bp_enter got in_ready=%b wb_valid=%b data=%h exp 0/1/1", in_ready, wb_valid, wb_data);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (in_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 32'd1 || wb_rd !== 3'd1 || alu_b !== 32'd2) begin
        miscompares++;
        $display("FAIL bp_hold%0d got in_ready=%b valid=%b data=%h rd=%0d alu_b=%h exp 0/1/1/1/2",
                 i, in_ready, wb_valid, wb_data, wb_rd, alu_b);
      end
    end
    vectors++;
    if (q_data.size() != 0) begin miscompares++; $display("FAIL bp_no_handshake got=%0d exp=0", q_data.size()); end
    wb_ready = 1'b1;
    step();
    set_idle();
    step(); step(); step();
    vectors++;
    if (q_data.size() != 3) begin
      miscompares++;
      $display("FAIL bp_release_count got=%0d exp=3", q_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (q_data[i] !== 32'(i + 1) || q_rd[i] !== 3'(i + 1)) begin
          miscompares++;
          $display("FAIL bp_release%0d got rd=%0d data=%h exp rd=%0d data=%0d", i, q_rd[i], q_data[i], i + 1, i + 1);
        end
      end
    end
  endtask

  task automatic test_r0_zero();
    clear_log();
    issue(4'd0, 3'd0, 3'd0, 3'd0, 32'h0000_FFFF, 1'b1);
    issue(4'd3, 3'd4, 3'd0, 3'd0, 32'd0, 1'b0);
    set_idle();
    step(); step();
    vectors++;
    if (q_data.size() != 2) begin
      miscompares++;
      $display("FAIL r0_count got=%0d exp=2", q_data.size());
    end else begin
      vectors++;
      if (q_data[0] !== 32'h0000_FFFF || q_rd[0] !== 3'd0) begin
        miscompares++;
        $display("FAIL r0_first got rd=%0d data=%h exp rd=0 data=0000ffff", q_rd[0], q_data[0]);
      end
      vectors++;
      if (q_data[1] !== 32'd0 || q_zero[1] !== 1'b1 || q_rd[1] !== 3'd4) begin
        miscompares++;
        $display("FAIL r0_or got rd=%0d data=%h zero=%b exp rd=4 data=0 zero=1", q_rd[1], q_data[1], q_zero[1]);
      end
    end
  endtask

  task automatic test_shift_cmp();
    logic [31:0] exp_d[4];
    logic        exp_z[4];
    exp_d = '{32'hFFFF_FFFF, 32'd1, 32'h0000_000F, 32'd0};
    exp_z = '{1'b0, 1'b0, 1'b0, 1'b1};
    clear_log();
    issue(4'd0, 3'd5, 3'd0, 3'd0, 32'hFFFF_FFFF, 1'b1);
    issue(4'd5, 3'd6, 3'd5, 3'd0, 32'd1, 1'b1);
    issue(4'd7, 3'd7, 3'd5, 3'd0, 32'd28, 1'b1);
    issue(4'd9, 3'd2, 3'd5, 3'd0, 32'd3, 1'b1);
    set_idle();
    step(); step(); step();
    vectors++;
    if (q_data.size() != 4) begin
      miscompares++;
      $display("FAIL shcmp_count got=%0d exp=4", q_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (q_data[i] !== exp_d[i] || q_zero[i] !== exp_z[i]) begin
          miscompares++;
          $display("FAIL shcmp_result%0d got data=%h zero=%b exp data=%h zero=%b", i, q_data[i], q_zero[i], exp_d[i], exp_z[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    clear_log();
    issue(4'd0, 3'd4, 3'd0, 3'd0, 32'h55, 1'b1);
    issue(4'd0, 3'd3, 3'd0, 3'd0, 32'h66, 1'b1);
    set_idle();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_flush got wb_valid=%b in_ready=%b a=%h b=%h exp 0/1/0/0", wb_valid, in_ready, alu_a, alu_b);
    end
    step();
    rst_n = 1'b1;
    for (int k = 1; k < 8; k++) issue(4'd3, 3'd0, 3'(k), 3'd0, 32'd0, 1'b0);
    set_idle();
    step(); step();
    vectors++;
    if (q_data.size() != 7) begin
      miscompares++;
      $display("FAIL midrst_count got=%0d exp=7", q_data.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        vectors++;
        if (q_data[k] !== 32'd0 || q_zero[k] !== 1'b1) begin
          miscompares++;
          $display("FAIL midrst_r%0d got data=%h zero=%b exp 0/1", k + 1, q_data[k], q_zero[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_back_to_back();
    test_backpressure();
    test_r0_zero();
    test_shift_cmp();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
